bcd_serial_alu: RTL and testbench

- Parametrised digit-serial BCD arithmetic unit for the calculator datapath.
- Takes two sign-magnitude BCD operands from the operand registers and an op_code from the operator register, then computes add, subtract or pass-through one BCD digit per clock.
- Raises done when the result is valid; the result feeds the display mux and the memory register.
- Replaces the fixed 3-digit, combinational execute path with a width-generic, handshaked unit that supports signed results.

---
 rtl/bcd_serial_alu_if.sv | 28 ++
 rtl/bcd_serial_alu.sv | 184 ++++++++++++++++++
 tb/tb_bcd_serial_alu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bcd_serial_alu_if.sv
// Operand/result bundle for the digit-serial BCD unit.
// The master drives a request and the slave returns the held result.
interface bcd_serial_alu_if #(
    parameter int DIGITS = 3
);
    logic                  start;
    logic [1:0]            op_code;
    logic [4*DIGITS-1:0]   a_bcd;
    logic                  a_sign;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  b_sign;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result_bcd;
    logic                  result_sign;
    logic                  overflow;
    logic                  invalid;

    modport master (
        output start, op_code, a_bcd, a_sign, b_bcd, b_sign,
        input  busy, done, result_bcd, result_sign, overflow, invalid
    );

    modport slave (
        input  start, op_code, a_bcd, a_sign, b_bcd, b_sign,
        output busy, done, result_bcd, result_sign, overflow, invalid
    );
endinterface

// File: rtl/bcd_serial_alu.sv
// Digit-serial sign-magnitude BCD add / subtract / pass unit.
// One digit per clock, LS digit first; a negative partial difference is
// turned into its ten's complement in a second serial pass (FIX).
module bcd_serial_alu #(
    parameter int DIGITS = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    bcd_serial_alu_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      cy_q, cy_d;
    logic [DIGITS-1:0][3:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic                      sgn_q, sgn_d, sub_q, sub_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [DIGITS-1:0][3:0]    result_bcd_q, result_bcd_d;
    logic                      result_sign_q, result_sign_d;
    logic                      overflow_q, overflow_d, invalid_q, invalid_d;

    logic                      bad_in, last, cy_n, eff_a_sign, eff_b_sign;
    logic [3:0]                da, db, dr, dig;
    logic [4:0]                sum, dif, cpl;

    // Flag any non-decimal nibble on the incoming operands.
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a_bcd[4*i +: 4] > 4'd9 || bus.b_bcd[4*i +: 4] > 4'd9)
                bad_in = 1'b1;
        end
    end

    // Next-state, per-digit arithmetic and result capture.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cy_d          = cy_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        sgn_d         = sgn_q;
        sub_d         = sub_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_bcd_d  = result_bcd_q;
        result_sign_d = result_sign_q;
        overflow_d    = overflow_q;
        invalid_d     = invalid_q;
        dig           = 4'd0;
        cy_n          = 1'b0;

        // pass B borrows B's sign for the zeroed A; subtract flips B's sign
        eff_a_sign = (bus.op_code == 2'b11) ? bus.b_sign : bus.a_sign;
        eff_b_sign = bus.b_sign ^ (bus.op_code == 2'b01);

        da   = a_q[idx_q];
        db   = b_q[idx_q];
        dr   = acc_q[idx_q];
        sum  = {1'b0, da} + {1'b0, db} + {4'b0, cy_q};
        dif  = {1'b0, da} - {1'b0, db} - {4'b0, cy_q};
        cpl  = {1'b0, 4'd9 - dr} + {4'b0, cy_q};
        last = (idx_q == IW'(DIGITS - 1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bad_in) begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        result_bcd_d  = '0;
                        result_sign_d = 1'b0;
                        overflow_d    = 1'b0;
                        invalid_d     = 1'b1;
                    end else begin
                        state_d = CHECK;
                        busy_d  = 1'b1;
                        a_d     = (bus.op_code == 2'b11) ? '0 : bus.a_bcd;
                        b_d     = (bus.op_code == 2'b10) ? '0 : bus.b_bcd;
                        sgn_d   = eff_a_sign;
                        sub_d   = (eff_a_sign != eff_b_sign);
                        idx_d   = '0;
                        cy_d    = 1'b0;
                        acc_d   = '0;
                    end
                end
            end
            CHECK, RUN: begin
                if (sub_q) begin
                    cy_n = dif[4];
                    dig  = cy_n ? 4'(dif + 5'd10) : dif[3:0];
                end else begin
                    cy_n = (sum > 5'd9);
                    dig  = cy_n ? 4'(sum - 5'd10) : sum[3:0];
                end
                acc_d[idx_q] = dig;
                cy_d         = cy_n;
                idx_d        = idx_q + IW'(1);
                state_d      = RUN;
                if (last) begin
                    idx_d = '0;
                    if (sub_q && cy_n) begin
                        state_d = FIX;
                        cy_d    = 1'b1;
                    end else begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        result_bcd_d  = acc_d;
                        overflow_d    = !sub_q && cy_n;
                        invalid_d     = 1'b0;
                        // zero magnitude is never negative unless it wrapped
                        result_sign_d = (acc_d == '0 && !(!sub_q && cy_n)) ? 1'b0 : sgn_q;
                    end
                end
            end
            FIX: begin
                cy_n         = (cpl > 5'd9);
                dig          = cy_n ? 4'(cpl - 5'd10) : cpl[3:0];
                acc_d[idx_q] = dig;
                cy_d         = cy_n;
                idx_d        = idx_q + IW'(1);
                if (last) begin
                    idx_d         = '0;
                    state_d       = DONE;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    result_bcd_d  = acc_d;
                    overflow_d    = 1'b0;
                    invalid_d     = 1'b0;
                    result_sign_d = (acc_d == '0) ? 1'b0 : ~sgn_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cy_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            sgn_q         <= 1'b0;
            sub_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_bcd_q  <= '0;
            result_sign_q <= 1'b0;
            overflow_q    <= 1'b0;
            invalid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cy_q          <= cy_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            sgn_q         <= sgn_d;
            sub_q         <= sub_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_bcd_q  <= result_bcd_d;
            result_sign_q <= result_sign_d;
            overflow_q    <= overflow_d;
            invalid_q     <= invalid_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_bcd  = result_bcd_q;
    assign bus.result_sign = result_sign_q;
    assign bus.overflow    = overflow_q;
    assign bus.invalid     = invalid_q;
endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed bench for bcd_serial_alu with DIGITS=3.
module tb_bcd_serial_alu;
    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   pulses;

    bcd_serial_alu_if #(.DIGITS(3)) bus ();

    bcd_serial_alu #(.DIGITS(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for done, check latency and held outputs.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [11:0] a, input logic as_,
                          input logic [11:0] b, input logic bs,
                          input int lat, input logic [11:0] res,
                          input logic rs, input logic ov, input logic inv);
        bus.op_code = op;
        bus.a_bcd   = a;
        bus.a_sign  = as_;
        bus.b_bcd   = b;
        bus.b_sign  = bs;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
            tick;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_res"}, {20'b0, bus.result_bcd}, {20'b0, res});
        chk({tag, "_sign"}, {31'b0, bus.result_sign}, {31'b0, rs});
        chk({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, ov});
        chk({tag, "_inv"}, {31'b0, bus.invalid}, {31'b0, inv});
        tick;
        chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_hold"}, {20'b0, bus.result_bcd}, {20'b0, res});
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op_code = 2'b00;
        bus.a_bcd   = '0;
        bus.a_sign  = 1'b0;
        bus.b_bcd   = '0;
        bus.b_sign  = 1'b0;
        #12;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_res", {20'b0, bus.result_bcd}, 32'd0);
        chk("rst_flags", {29'b0, bus.result_sign, bus.overflow, bus.invalid}, 32'd0);
        tick;
        reset_n = 1'b1;
        tick;

        run_op("add",      2'b00, 12'h123, 1'b0, 12'h456, 1'b0, 4, 12'h579, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",  2'b00, 12'h999, 1'b0, 12'h001, 1'b0, 4, 12'h000, 1'b0, 1'b1, 1'b0);
        run_op("sub_brw",  2'b01, 12'h100, 1'b0, 12'h250, 1'b0, 7, 12'h150, 1'b1, 1'b0, 1'b0);
        run_op("sub_nb",   2'b01, 12'h456, 1'b0, 12'h123, 1'b0, 4, 12'h333, 1'b0, 1'b0, 1'b0);
        run_op("neg_zero", 2'b01, 12'h005, 1'b1, 12'h005, 1'b1, 4, 12'h000, 1'b0, 1'b0, 1'b0);
        run_op("mix_add",  2'b00, 12'h020, 1'b1, 12'h050, 1'b0, 7, 12'h030, 1'b0, 1'b0, 1'b0);
        run_op("pass_a",   2'b10, 12'h321, 1'b1, 12'h888, 1'b0, 4, 12'h321, 1'b1, 1'b0, 1'b0);

        // second start while busy and a start in the DONE cycle are ignored
        bus.op_code = 2'b00;
        bus.a_bcd   = 12'h123;
        bus.a_sign  = 1'b0;
        bus.b_bcd   = 12'h456;
        bus.b_sign  = 1'b0;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        tick;
        bus.op_code = 2'b01;
        bus.a_bcd   = 12'h111;
        bus.b_bcd   = 12'h222;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        tick;
        chk("hs_done_c4", {31'b0, bus.done}, 32'd1);
        chk("hs_res", {20'b0, bus.result_bcd}, 32'h579);
        chk("hs_sign", {31'b0, bus.result_sign}, 32'd0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done || bus.busy) pulses++;
            tick;
        end
        chk("hs_no_extra", pulses, 0);

        // reset mid-operation clears everything with no done afterwards
        bus.op_code = 2'b00;
        bus.a_bcd   = 12'h100;
        bus.b_bcd   = 12'h200;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        tick;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
        chk("mid_rst_res", {20'b0, bus.result_bcd}, 32'd0);
        chk("mid_rst_flags", {29'b0, bus.result_sign, bus.overflow, bus.invalid}, 32'd0);
        tick;
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) pulses++;
            tick;
        end
        chk("mid_rst_no_done", pulses, 0);

        run_op("invalid", 2'b00, 12'h1A3, 1'b0, 12'h000, 1'b0, 1, 12'h000, 1'b0, 1'b0, 1'b1);
        run_op("pass_b",  2'b11, 12'h777, 1'b0, 12'h042, 1'b1, 4, 12'h042, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
